// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 4-digit seven-segment scan controller with frame-synchronous double buffering; define SEG_SCAN_LEADING_ZERO_BLANK_EN to darken leading-zero digits
module seg_scan_ctrl #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        load,
  input  logic [15:0] value,
  output logic [3:0]  nibble,
  output logic [3:0]  an,
  output logic [1:0]  digit_idx,
  output logic        frame_done,
  output logic        load_pending
);
  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;
  state_t        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   disp_q, disp_d, pend_q, pend_d;
  logic          pending_q, pending_d, frame_done_q, frame_done_d;
  logic          boundary, lz_dark;
  // Scan sequencing, frame-boundary commit and load buffering
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    disp_d       = disp_q;
    pend_d       = pend_q;
    pending_d    = pending_q;
    frame_done_d = 1'b0;
    boundary     = 1'b0;
    case (state_q)
      IDLE: if (enable) begin
        state_d = BLANK;
        idx_d   = 2'd0;
        cnt_d   = '0;
      end
      BLANK: if (!enable) begin
        state_d = IDLE;
        idx_d   = 2'd0;
        cnt_d   = '0;
      end else begin
        cnt_d   = cnt_q + CW'(1);
        state_d = (cnt_q == CW'(BLANK_CYCLES - 1)) ? SHOW : BLANK;
      end
      SHOW: if (!enable) begin
        state_d = IDLE;
        idx_d   = 2'd0;
        cnt_d   = '0;
      end else if (cnt_q == CW'(REFRESH_DIV - 1)) begin
        state_d  = BLANK;
        cnt_d    = '0;
        idx_d    = idx_q + 2'd1;
        boundary = (idx_q == 2'd3);
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      default: state_d = IDLE;
    endcase
    if (boundary) begin
      frame_done_d = 1'b1;
      disp_d       = pending_q ? pend_q : disp_q;
      pending_d    = 1'b0;
    end
    if (load && (state_q == IDLE || boundary)) begin
      disp_d    = value;
      pending_d = 1'b0;
    end else if (load) begin
      pend_d    = value;
      pending_d = 1'b1;
    end
  end
  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= 2'd0;
      cnt_q        <= '0;
      disp_q       <= 16'h0;
      pend_q       <= 16'h0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
    end
  end
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
  assign lz_dark = (idx_q != 2'd0) && ((disp_q >> {idx_q, 2'b00}) == 16'h0);
`else
  assign lz_dark = 1'b0;
`endif
  assign nibble       = (state_q == IDLE) ? 4'h0 : disp_q[{idx_q, 2'b00} +: 4];
  assign an           = (state_q == SHOW && !lz_dark) ? ~(4'b0001 << idx_q) : 4'b1111;
  assign digit_idx    = idx_q;
  assign frame_done   = frame_done_q;
  assign load_pending = pending_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed checks of scan timing, buffering, disable and reset
module tb_seg_scan_ctrl;
  logic        clk = 1'b0;
  logic        rst, enable, load;
  logic [15:0] value;
  logic [3:0]  nibble, an;
  logic [1:0]  digit_idx;
  logic        frame_done, load_pending;
  int          errors = 0;
  int          checks = 0;

  seg_scan_ctrl #(.REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .enable(enable), .load(load), .value(value),
    .nibble(nibble), .an(an), .digit_idx(digit_idx),
    .frame_done(frame_done), .load_pending(load_pending)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_cycle(input int c, input logic [15:0] d);
    int s, p;
    logic [3:0] exp_an;
    logic [15:0] dv;
    s = (c / 8) % 4;
    p = c % 8;
    dv = d;
    exp_an = (p < 2) ? 4'b1111 : ~(4'b0001 << s);
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
    if (s > 0 && (dv >> (4 * s)) == 16'h0) exp_an = 4'b1111;
`endif
    chk($sformatf("an_c%0d", c), {12'h0, an}, {12'h0, exp_an});
    chk($sformatf("nib_c%0d", c), {12'h0, nibble}, {12'h0, dv[4*s +: 4]});
    chk($sformatf("idx_c%0d", c), {14'h0, digit_idx}, 16'(s));
    chk($sformatf("fd_c%0d", c), {15'h0, frame_done}, {15'h0, (c > 0 && c % 32 == 0)});
  endtask

  initial begin
    logic [15:0] d;
    logic pend_exp;
    rst = 1'b1; enable = 1'b1; load = 1'b1; value = 16'hFFFF;
    step(); step();
    chk("rst_an", {12'h0, an}, 16'h000F);
    chk("rst_nib", {12'h0, nibble}, 16'h0);
    chk("rst_idx", {14'h0, digit_idx}, 16'h0);
    chk("rst_fd", {15'h0, frame_done}, 16'h0);
    chk("rst_pend", {15'h0, load_pending}, 16'h0);
    rst = 1'b0; enable = 1'b0; load = 1'b0;
    step();
    chk("idle_an", {12'h0, an}, 16'h000F);
    enable = 1'b1;
    step();
    chk("rst_noload_nib", {12'h0, nibble}, 16'h0);
    chk("rst_noload_an", {12'h0, an}, 16'h000F);
    enable = 1'b0;
    step();
    load = 1'b1; value = 16'h1234;
    step();
    chk("idle_load_pend", {15'h0, load_pending}, 16'h0);
    load = 1'b0; enable = 1'b1;
    step();
    for (int g = 0; g <= 84; g++) begin
      d = (g < 32) ? 16'h1234 : (g < 64) ? 16'hABCD : 16'h5555;
      pend_exp = (g >= 13 && g <= 31) || (g >= 45 && g <= 63);
      chk_cycle(g, d);
      chk($sformatf("pend_c%0d", g), {15'h0, load_pending}, {15'h0, pend_exp});
      if (g == 12) begin load = 1'b1; value = 16'hABCD; end
      if (g == 44) begin load = 1'b1; value = 16'h00F0; end
      if (g == 63) begin load = 1'b1; value = 16'h5555; end
      if (g == 84) enable = 1'b0;
      step();
      load = 1'b0;
    end
    chk("dis_an", {12'h0, an}, 16'h000F);
    chk("dis_idx", {14'h0, digit_idx}, 16'h0);
    chk("dis_nib", {12'h0, nibble}, 16'h0);
    enable = 1'b1;
    step();
    chk("reen_b0_an", {12'h0, an}, 16'h000F);
    chk("reen_b0_idx", {14'h0, digit_idx}, 16'h0);
    chk("reen_b0_nib", {12'h0, nibble}, 16'h5);
    step();
    chk("reen_b1_an", {12'h0, an}, 16'h000F);
    step();
    chk("reen_show_an", {12'h0, an}, 16'h000E);
    chk("reen_show_nib", {12'h0, nibble}, 16'h5);
    load = 1'b1; value = 16'h9876;
    step();
    load = 1'b0;
    chk("show_load_pend", {15'h0, load_pending}, 16'h1);
    rst = 1'b1;
    step();
    chk("midrst_an", {12'h0, an}, 16'h000F);
    chk("midrst_nib", {12'h0, nibble}, 16'h0);
    chk("midrst_idx", {14'h0, digit_idx}, 16'h0);
    chk("midrst_pend", {15'h0, load_pending}, 16'h0);
    chk("midrst_fd", {15'h0, frame_done}, 16'h0);
    rst = 1'b0;
    step();
    chk("postrst_blank_nib", {12'h0, nibble}, 16'h0);
    chk("postrst_blank_an", {12'h0, an}, 16'h000F);
    rst = 1'b1; enable = 1'b0;
    step();
    rst = 1'b0; load = 1'b1; value = 16'h0050;
    step();
    load = 1'b0; enable = 1'b1;
    step();
    for (int g = 0; g <= 32; g++) begin
      chk_cycle(g, 16'h0050);
      step();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
